vram_bus_ctrl: RTL

Memory-side controller that sits directly downstream of the VDP's VRAM port.
- Accepts the VDP's asynchronous-style strobed VRAM bus (SEL/CE_N/UB_N/LB_N/WE_N/OE_N) and converts it into byte-lane accesses on a dual-port block RAM (port A = upper byte, port B = lower byte).
- Returns registered read data and a held-low DTACK_N handshake.
- Replaces the ad-hoc two-state DTACK logic in the top level with a latency-correct FSM.

---
 rtl/genesis_vram_pkg.sv | 8 +
 rtl/vram_bus_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/genesis_vram_pkg.sv
// genesis_vram_pkg: shared FSM type and constants for the VDP VRAM bus controller.
package genesis_vram_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ACK} state_t;
  localparam int VRAM_ADDR_W  = 15;
  localparam int VRAM_LAT_MAX = 4;
  localparam int LANE_HI      = 0;
  localparam int LANE_LO      = 1;
endpackage

// File: rtl/vram_bus_ctrl.sv
// vram_bus_ctrl: VDP strobed VRAM bus to dual-port byte-lane BRAM bridge with DTACK_N handshake.
// Define VRAM_STATS_EN to add the RD_CNT/WR_CNT access counters.
module vram_bus_ctrl
  import genesis_vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int RD_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              VRAM_SEL,
  input  logic              VRAM_CE_N,
  input  logic              VRAM_UB_N,
  input  logic              VRAM_LB_N,
  input  logic              VRAM_WE_N,
  input  logic              VRAM_OE_N,
  input  logic [ADDR_W-1:0] VRAM_ADDR,
  input  logic [15:0]       VRAM_DI,
  output logic [15:0]       VRAM_DO,
  output logic              VRAM_DTACK_N,
  output logic [ADDR_W:0]   MEM_ADDR_A,
  output logic [ADDR_W:0]   MEM_ADDR_B,
  output logic              MEM_EN_A,
  output logic              MEM_EN_B,
  output logic              MEM_WE_A,
  output logic              MEM_WE_B,
  output logic [7:0]        MEM_DIN_A,
  output logic [7:0]        MEM_DIN_B,
  input  logic [7:0]        MEM_DOUT_A,
  input  logic [7:0]        MEM_DOUT_B
`ifdef VRAM_STATS_EN
  ,
  output logic [15:0]       RD_CNT,
  output logic [15:0]       WR_CNT
`endif
);
  localparam int CNT_W = $clog2(VRAM_LAT_MAX);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_lane;
  logic              r_wr;
  logic [15:0]       r_di, r_do;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_req, w_issue, w_unused;
  assign w_req        = VRAM_SEL & ~VRAM_CE_N;
  assign w_issue      = r_state == ISSUE;
  assign w_unused     = VRAM_OE_N;
  assign MEM_ADDR_A   = {r_addr, 1'b0};
  assign MEM_ADDR_B   = {r_addr, 1'b1};
  assign MEM_DIN_A    = r_di[15:8];
  assign MEM_DIN_B    = r_di[7:0];
  // Enables decode straight from state so an async reset drops them at once
  assign MEM_EN_A     = w_issue & r_lane[LANE_HI];
  assign MEM_EN_B     = w_issue & r_lane[LANE_LO];
  assign MEM_WE_A     = MEM_EN_A & r_wr;
  assign MEM_WE_B     = MEM_EN_B & r_wr;
  assign VRAM_DO      = r_do;
  assign VRAM_DTACK_N = r_state != ACK;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_req ? ISSUE : IDLE;
      ISSUE:   w_next = (r_wr || r_lane == 2'b00) ? DONE : WAIT;
      WAIT:    w_next = (r_cnt == '0) ? DONE : WAIT;
      DONE:    w_next = VRAM_SEL ? ACK : IDLE;
      ACK:     w_next = VRAM_SEL ? ACK : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_lane  <= '0;
      r_wr    <= 1'b0;
      r_di    <= '0;
      r_do    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_addr          <= VRAM_ADDR;
        r_lane[LANE_HI] <= ~VRAM_UB_N;
        r_lane[LANE_LO] <= ~VRAM_LB_N;
        r_wr            <= ~VRAM_WE_N;
        r_di            <= VRAM_DI;
      end
      if (w_issue)
        r_cnt <= CNT_W'(RD_LAT - 1);
      else if (r_state == WAIT)
        r_cnt <= r_cnt - CNT_W'(1);
      if (r_state == WAIT && r_cnt == '0)
        r_do <= {r_lane[LANE_HI] ? MEM_DOUT_A : 8'h00, r_lane[LANE_LO] ? MEM_DOUT_B : 8'h00};
    end
  end
`ifdef VRAM_STATS_EN
  // Counted at ISSUE, so aborted and no-lane accesses are included
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RD_CNT <= '0;
      WR_CNT <= '0;
    end else if (w_issue) begin
      if (r_wr)
        WR_CNT <= WR_CNT + 16'd1;
      else
        RD_CNT <= RD_CNT + 16'd1;
    end
  end
`endif
endmodule
